// File: rtl/multi_channel_blackbox_checker_pkg.sv
// Shared types, constants and the stimulus pattern for the black-box checker.
package multi_channel_blackbox_checker_pkg;

    // Width of the mismatch counter.
    localparam int unsigned ERR_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck,
        StDone
    } state_e;

    // Stimulus word for vector v on channel c. The caller truncates to its channel
    // width, which gives the mod 2^WIDTH wrap. All-ones is exact for widths up to 32.
    function automatic logic [31:0] stim_word(input logic [31:0] v, input logic [31:0] c);
        logic [31:0] w_word;
        if (v == 32'd0) begin
            w_word = '0;
        end else if (v == 32'd1) begin
            w_word = '1;
        end else begin
            w_word = 32'd3 * v + c;
        end
        return w_word;
    endfunction

endpackage

// File: rtl/multi_channel_blackbox_checker_stim_gen.sv
// Combinational stimulus generator: maps a vector index to one word per channel.
module bb_stim_gen
    import multi_channel_blackbox_checker_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned VEC_W    = 4
) (
    input  logic [VEC_W-1:0]          i_vec,
    output logic [CHANNELS*WIDTH-1:0] o_stim
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        // One stimulus word per channel slice.
        assign o_stim[c*WIDTH +: WIDTH] = WIDTH'(stim_word(32'(i_vec), 32'(c)));
    end

endmodule

// File: rtl/multi_channel_blackbox_checker.sv
// Drives a fixed vector set into a bank of black-box channels and checks each
// returned slice against its expected passthrough or inverted value.
module multi_channel_blackbox_checker
    import multi_channel_blackbox_checker_pkg::*;
#(
    parameter int unsigned         CHANNELS      = 4,
    parameter int unsigned         WIDTH         = 8,
    parameter int unsigned         NUM_VECTORS   = 16,
    parameter int unsigned         SETTLE_CYCLES = 1,
    parameter logic [CHANNELS-1:0] MODE_MASK     = 4'b0101,
    localparam int unsigned        CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned        VW = $clog2(NUM_VECTORS),
    localparam int unsigned        SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic [CHANNELS*WIDTH-1:0] stim_out,
    input  logic [CHANNELS*WIDTH-1:0] dut_in,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_count,
    output logic                      err_valid,
    output logic [CW-1:0]             first_fail_chan,
    output logic [VW-1:0]             first_fail_vec
);

    state_e                    r_state;
    state_e                    w_state_d;
    logic [VW-1:0]             r_vec;
    logic [VW-1:0]             w_vec_d;
    logic [SW-1:0]             r_settle;
    logic [CHANNELS*WIDTH-1:0] r_stim;
    logic [CHANNELS*WIDTH-1:0] w_stim_next;
    logic [ERR_W-1:0]          r_err_count;
    logic                      r_err_valid;
    logic [CW-1:0]             r_ff_chan;
    logic [VW-1:0]             r_ff_vec;

    logic                      w_load_stim;
    logic                      w_clear;
    logic [CHANNELS-1:0]       w_mismatch;
    logic                      w_any;
    logic [ERR_W-1:0]          w_mm_count;
    logic [CW-1:0]             w_first_chan;
    logic [ERR_W:0]            w_sum;
    logic [ERR_W-1:0]          w_err_d;

    // Stimulus is computed for the index about to be entered so it can be registered
    // on the same edge that enters DRIVE.
    bb_stim_gen #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .VEC_W    (VW)
    ) u_stim_gen (
        .i_vec  (w_vec_d),
        .o_stim (w_stim_next)
    );

    // Next-state logic: run sequencing, vector advance and run-start clear.
    always_comb begin
        w_state_d   = r_state;
        w_vec_d     = r_vec;
        w_load_stim = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_d   = StDrive;
                    w_vec_d     = '0;
                    w_load_stim = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            StDrive: begin
                if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                    w_state_d = StCheck;
                end
            end
            StCheck: begin
                if (r_vec == VW'(NUM_VECTORS - 1)) begin
                    w_state_d = StDone;
                end else begin
                    w_state_d   = StDrive;
                    w_vec_d     = r_vec + 1'b1;
                    w_load_stim = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Per-channel compare against the mode-dependent expectation.
    always_comb begin
        w_mismatch = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_mismatch[c] = dut_in[c*WIDTH +: WIDTH] !=
                            (MODE_MASK[c] ? ~r_stim[c*WIDTH +: WIDTH] : r_stim[c*WIDTH +: WIDTH]);
        end
    end

    // Mismatch population count and lowest failing channel; descending scan so the
    // lowest index is written last.
    always_comb begin
        w_mm_count   = '0;
        w_first_chan = '0;
        for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
            if (w_mismatch[c]) begin
                w_mm_count   = w_mm_count + 1'b1;
                w_first_chan = CW'(c);
            end
        end
    end

    // Single accumulate with saturation at all-ones.
    always_comb begin
        w_any   = |w_mismatch;
        w_sum   = {1'b0, r_err_count} + {1'b0, w_mm_count};
        w_err_d = w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
    end

    // FSM state, vector index and registered stimulus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_vec   <= '0;
            r_stim  <= '0;
        end else begin
            r_state <= w_state_d;
            r_vec   <= w_vec_d;
            if (w_load_stim) begin
                r_stim <= w_stim_next;
            end
        end
    end

    // Counts DRIVE cycles of the current vector; idles at zero elsewhere.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_settle <= '0;
        end else if (r_state == StDrive) begin
            r_settle <= r_settle + 1'b1;
        end else begin
            r_settle <= '0;
        end
    end

    // Error accumulation, mismatch pulse and first-failure capture. A zero count
    // means no failure yet, since the counter saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
            r_err_valid <= 1'b0;
            r_ff_chan   <= '0;
            r_ff_vec    <= '0;
        end else begin
            r_err_valid <= (r_state == StCheck) && w_any;
            if (w_clear) begin
                r_err_count <= '0;
                r_ff_chan   <= '0;
                r_ff_vec    <= '0;
            end else if (r_state == StCheck) begin
                r_err_count <= w_err_d;
                if (w_any && (r_err_count == '0)) begin
                    r_ff_chan <= w_first_chan;
                    r_ff_vec  <= r_vec;
                end
            end
        end
    end

    assign stim_out        = r_stim;
    assign busy            = (r_state == StDrive) || (r_state == StCheck);
    assign done            = (r_state == StDone);
    assign pass            = done && (r_err_count == '0);
    assign err_count       = r_err_count;
    assign err_valid       = r_err_valid;
    assign first_fail_chan = r_ff_chan;
    assign first_fail_vec  = r_ff_vec;

endmodule
